// File: rtl/down_counter_pkg.sv
// Shared types and constants for the loadable down counter / interval timer.
package down_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dc_state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter: counts a captured value to zero, pulses tc for one cycle
// on expiry, then either stops (one-shot) or restarts from the captured value.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mode,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  dc_state_t        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;

  // Priority: load > enabled decrement > hold.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and infers a latch.
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;

    if (load) begin
      if (load_value != '0) begin
        count_d  = load_value;
        reload_d = load_value;
        mode_d   = mode;
        state_d  = RUN;
      end else begin
        // A zero load expires immediately rather than entering RUN.
        count_d = '0;
        state_d = IDLE;
        tc_d    = 1'b1;
      end
    end else if (state_q == RUN && en) begin
      if (count_q == WIDTH'(1)) begin
        tc_d = 1'b1;
        if (mode_q == MODE_RELOAD) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end else if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign tc    = tc_q;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios with fixed expectations
// plus a randomized run compared against a behavioural timer model.
module tb_down_counter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             mode;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;

  int checks;
  int failures;

  // Behavioural model: remaining ticks, period, auto-reload flag, running flag.
  int m_count;
  int m_period;
  bit m_auto;
  bit m_run;
  bit m_tc;

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_value(load_value),
    .mode      (mode),
    .en        (en),
    .count     (count),
    .busy      (busy),
    .tc        (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_count  = 0;
    m_period = 0;
    m_auto   = 1'b0;
    m_run    = 1'b0;
    m_tc     = 1'b0;
  endtask

  // One clock edge of the timer, described as what the user would observe.
  task automatic model_edge(input bit l, input int lv, input bit md, input bit e);
    m_tc = 1'b0;
    if (l) begin
      if (lv == 0) begin
        m_count = 0;
        m_run   = 1'b0;
        m_tc    = 1'b1;
      end else begin
        m_count  = lv;
        m_period = lv;
        m_auto   = md;
        m_run    = 1'b1;
      end
    end else if (m_run && e) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_tc = 1'b1;
        if (m_auto) m_count = m_period;
        else        m_run   = 1'b0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".busy"},  32'(busy),  32'(m_run));
    check({tag, ".tc"},    32'(tc),    32'(m_tc));
  endtask

  // Drive inputs, take one edge, then compare against the model 1 unit later.
  task automatic step(input bit l, input int lv, input bit md, input bit e, input string tag);
    load       = l;
    load_value = WIDTH'(lv);
    mode       = md;
    en         = e;
    @(posedge clk);
    #1;
    model_edge(l, lv, md, e);
    check_model(tag);
  endtask

  initial begin
    int exp_auto[9];
    int exp_pause[7];
    bit exp_pause_en[7];

    checks   = 0;
    failures = 0;
    reset      = 1'b0;
    load       = 1'b0;
    load_value = '0;
    mode       = 1'b0;
    en         = 1'b0;
    model_reset();

    // Power-on reset.
    #1 reset = 1'b1;
    #1;
    check("por.count", 32'(count), 32'd0);
    check("por.busy",  32'(busy),  32'd0);
    check("por.tc",    32'(tc),    32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: asynchronous reset mid-run at count 5.
    step(1'b1, 5, 1'b0, 1'b1, "rst_load");
    check("rst_load.const", 32'(count), 32'd5);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("rst_async.count", 32'(count), 32'd0);
    check("rst_async.busy",  32'(busy),  32'd0);
    check("rst_async.tc",    32'(tc),    32'd0);
    #2 reset = 1'b0;

    // 2: one-shot from 5.
    step(1'b1, 5, 1'b0, 1'b1, "os_load");
    for (int i = 4; i >= 0; i--) begin
      step(1'b0, 0, 1'b0, 1'b1, "oneshot");
      check("oneshot.count_const", 32'(count), 32'(i));
      check("oneshot.tc_const",    32'(tc),    32'(i == 0));
    end
    check("oneshot.busy_after", 32'(busy), 32'd0);
    step(1'b0, 0, 1'b0, 1'b1, "oneshot_hold");
    check("oneshot.no_wrap", 32'(count), 32'd0);

    // 3: auto-reload with period 3.
    exp_auto = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    step(1'b1, 3, 1'b1, 1'b1, "ar_load");
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 0, 1'b0, 1'b1, "autoreload");
      check("autoreload.count_const", 32'(count), 32'(exp_auto[i]));
      check("autoreload.tc_const",    32'(tc),    32'(exp_auto[i] == 3));
      check("autoreload.busy_const",  32'(busy),  32'd1);
    end

    // 4: pause holds count and suppresses tc.
    exp_pause    = '{3, 2, 2, 2, 2, 1, 0};
    exp_pause_en = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    step(1'b1, 4, 1'b0, 1'b1, "pause_load");
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 0, 1'b0, exp_pause_en[i], "pause");
      check("pause.count_const", 32'(count), 32'(exp_pause[i]));
      check("pause.tc_const",    32'(tc),    32'(i == 6));
    end

    // 5: load during RUN beats en and re-samples mode.
    step(1'b1, 4, 1'b0, 1'b1, "reld_load");
    step(1'b0, 0, 1'b0, 1'b1, "reld_dec");
    step(1'b0, 0, 1'b0, 1'b1, "reld_dec");
    check("reld.at2", 32'(count), 32'd2);
    step(1'b1, 9, 1'b1, 1'b1, "reld_over");
    check("reld.count9", 32'(count), 32'd9);
    check("reld.no_tc",  32'(tc),    32'd0);
    for (int i = 0; i < 9; i++) step(1'b0, 0, 1'b0, 1'b1, "reld_run");
    check("reld.reloaded", 32'(count), 32'd9);
    check("reld.tc",       32'(tc),    32'd1);
    check("reld.busy",     32'(busy),  32'd1);

    // 6: edge values 0 and 15.
    step(1'b1, 0, 1'b1, 1'b1, "zero_load");
    check("zero.count", 32'(count), 32'd0);
    check("zero.tc",    32'(tc),    32'd1);
    check("zero.busy",  32'(busy),  32'd0);
    step(1'b0, 0, 1'b0, 1'b1, "zero_after");
    check("zero.tc_once", 32'(tc), 32'd0);
    step(1'b1, 15, 1'b0, 1'b1, "max_load");
    check("max.count", 32'(count), 32'd15);
    for (int i = 0; i < 15; i++) step(1'b0, 0, 1'b0, 1'b1, "max_run");
    check("max.end_tc", 32'(tc), 32'd1);
    step(1'b0, 0, 1'b0, 1'b1, "max_after");
    check("max.no_wrap", 32'(count), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit r_load;
      r_load = ($urandom_range(0, 7) == 0);
      step(r_load, int'($urandom_range(0, 15)), 1'($urandom), ($urandom_range(0, 3) != 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
